// File: rtl/cache_req_arbiter_pkg.sv
// cache_req_arbiter_pkg: shared cache types, arbiter states and round-robin pick helper
package cachepkg;
    typedef enum logic [1:0] {INST_NOP, INST_READ, INST_WRITE, INST_FLUSH} inst_t;
    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} arb_state_t;
    localparam int ARB_MAX_CHAN = 16;
    // descending scan so the lowest offset from ptr wins
    function automatic logic [3:0] rr_pick(input logic [ARB_MAX_CHAN-1:0] req, input logic [3:0] ptr, input int n);
        logic [3:0] r;
        logic [3:0] k;
        r = ptr;
        for (int i = n - 1; i >= 0; i--) begin
            k = 4'((int'(ptr) + i) % n);
            if (req[k]) r = k;
        end
        return r;
    endfunction
endpackage

// File: rtl/cache_req_arbiter_select.sv
// rr_priority_select: combinational first-eligible-at-or-after-ptr selector
module rr_priority_select
    import cachepkg::*;
#(
    parameter int NCHAN = 4,
    parameter int GW = 2
) (
    input  logic [NCHAN-1:0] eligible,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    grant,
    output logic             any_eligible
);
    assign grant = GW'(rr_pick(ARB_MAX_CHAN'(eligible), 4'(ptr), NCHAN));
    assign any_eligible = |eligible;
endmodule

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin bridge of NCHAN 4-phase cache requesters onto one slave port
// Optional issue timeout with m_error enabled by CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter
    import cachepkg::*;
#(
    parameter int NCHAN = 4,
    parameter int DATAWIDTH = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int GW = NCHAN > 1 ? $clog2(NCHAN) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NCHAN-1:0]                    m_request,
    input  inst_t [NCHAN-1:0]                   m_operation,
    input  logic [NCHAN-1:0][ADDRESSWIDTH-1:0]  m_addr,
    input  logic [NCHAN-1:0][DATAWIDTH-1:0]     m_wdata,
    output logic [NCHAN-1:0]                    m_valid,
    output logic [DATAWIDTH-1:0]                m_rdata,
    output logic                                m_evict,
`ifdef CACHE_ARB_TIMEOUT_EN
    output logic                                m_error,
`endif
    output logic                                s_request,
    output inst_t                               s_operation,
    output logic [ADDRESSWIDTH-1:0]             s_addr,
    output logic [DATAWIDTH-1:0]                s_wdata,
    input  logic                                s_valid,
    input  logic                                s_evict,
    input  logic [DATAWIDTH-1:0]                s_rdata,
    output logic [GW-1:0]                       grant_id
);
    localparam logic [GW-1:0] LAST = GW'(NCHAN - 1);
    arb_state_t state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] sel;
    logic any;
`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
`endif

    rr_priority_select #(.NCHAN(NCHAN), .GW(GW)) u_sel (
        .eligible(m_request & ~m_valid),
        .ptr(rr_ptr),
        .grant(sel),
        .any_eligible(any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_id <= '0;
            m_valid <= '0;
            m_rdata <= '0;
            m_evict <= 1'b0;
            s_request <= 1'b0;
            s_operation <= INST_NOP;
            s_addr <= '0;
            s_wdata <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            m_error <= 1'b0;
            cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (any) begin
                    s_operation <= m_operation[sel];
                    s_addr <= m_addr[sel];
                    s_wdata <= m_wdata[sel];
                    grant_id <= sel;
                    s_request <= 1'b1;
                    state <= ISSUE;
`ifdef CACHE_ARB_TIMEOUT_EN
                    cnt <= '0;
`endif
                end
                ISSUE: if (s_valid) begin
                    m_rdata <= s_rdata;
                    m_evict <= s_evict;
                    s_request <= 1'b0;
                    m_valid[grant_id] <= 1'b1;
                    state <= COMPLETE;
`ifdef CACHE_ARB_TIMEOUT_EN
                    m_error <= 1'b0;
                end else if (cnt == TLAST) begin
                    m_rdata <= '0;
                    m_evict <= 1'b0;
                    m_error <= 1'b1;
                    s_request <= 1'b0;
                    m_valid[grant_id] <= 1'b1;
                    state <= COMPLETE;
                end else begin
                    cnt <= cnt + 1'b1;
`endif
                end
                COMPLETE: if (!m_request[grant_id] && !s_valid) begin
                    m_valid[grant_id] <= 1'b0;
                    rr_ptr <= grant_id == LAST ? '0 : grant_id + 1'b1;
                    grant_id <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: randomized 4-phase masters and slave against a round-robin reference model
module tb_cache_req_arbiter;
    import cachepkg::*;
    localparam int N = 4;
    localparam int TO = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] m_request = '0;
    inst_t [N-1:0] m_operation = '0;
    logic [N-1:0][31:0] m_addr = '0;
    logic [N-1:0][7:0] m_wdata = '0;
    logic [N-1:0] m_valid;
    logic [7:0] m_rdata;
    logic m_evict;
    logic s_request;
    inst_t s_operation;
    logic [31:0] s_addr;
    logic [7:0] s_wdata;
    logic s_valid = 1'b0;
    logic s_evict = 1'b0;
    logic [7:0] s_rdata = '0;
    logic [1:0] grant_id;

    logic m_request1 = 1'b0;
    inst_t [0:0] m_operation1 = '0;
    logic [0:0][31:0] m_addr1 = '0;
    logic [0:0][7:0] m_wdata1 = '0;
    logic m_valid1;
    logic [7:0] m_rdata1;
    logic m_evict1;
    logic s_request1;
    inst_t s_operation1;
    logic [31:0] s_addr1;
    logic [7:0] s_wdata1;
    logic s_valid1 = 1'b0;
    logic [7:0] s_rdata1 = '0;
    logic grant_id1;
`ifdef CACHE_ARB_TIMEOUT_EN
    logic m_error;
    logic m_error1;
`endif

    int tests = 0;
    int fails = 0;
    int rr = 0;

    cache_req_arbiter #(.NCHAN(N), .DATAWIDTH(8), .ADDRESSWIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .m_request(m_request), .m_operation(m_operation),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_valid(m_valid), .m_rdata(m_rdata), .m_evict(m_evict),
`ifdef CACHE_ARB_TIMEOUT_EN
        .m_error(m_error),
`endif
        .s_request(s_request), .s_operation(s_operation), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_valid(s_valid), .s_evict(s_evict), .s_rdata(s_rdata), .grant_id(grant_id)
    );

    cache_req_arbiter #(.NCHAN(1), .DATAWIDTH(8), .ADDRESSWIDTH(32), .TIMEOUT_CYCLES(TO)) dut1 (
        .clock(clock), .reset(reset), .m_request(m_request1), .m_operation(m_operation1),
        .m_addr(m_addr1), .m_wdata(m_wdata1), .m_valid(m_valid1), .m_rdata(m_rdata1), .m_evict(m_evict1),
`ifdef CACHE_ARB_TIMEOUT_EN
        .m_error(m_error1),
`endif
        .s_request(s_request1), .s_operation(s_operation1), .s_addr(s_addr1), .s_wdata(s_wdata1),
        .s_valid(s_valid1), .s_evict(1'b0), .s_rdata(s_rdata1), .grant_id(grant_id1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // reference: first requesting channel at or after rr, wrapping
    function automatic int pick();
        for (int i = 0; i < N; i++) if (m_request[2'((rr + i) % N)]) return (rr + i) % N;
        return -1;
    endfunction

    task automatic do_round(input logic [N-1:0] add, input int dly, input int rdi, input int evi, input int mode, input bit viol);
        int g;
        int waits;
        bit to;
        logic [7:0] rd;
        logic ev;
        logic [1:0] gi;
        for (int c = 0; c < N; c++) begin
            if (add[2'(c)] && !m_request[2'(c)]) begin
                m_operation[2'(c)] = inst_t'($urandom_range(0, 3));
                m_addr[2'(c)] = $urandom;
                m_wdata[2'(c)] = 8'($urandom);
                m_request[2'(c)] = 1'b1;
            end
        end
        g = pick();
        gi = 2'(g);
        rd = rdi < 0 ? 8'($urandom) : 8'(rdi);
        ev = evi < 0 ? 1'($urandom) : 1'(evi);
`ifdef CACHE_ARB_TIMEOUT_EN
        to = dly < 0 || dly >= TO;
`else
        to = 1'b0;
`endif
        waits = to ? TO - 1 : dly;
        tick;
        check("s_request_rise", s_request, 1);
        check("grant_id", grant_id, gi);
        check("s_addr", s_addr, m_addr[gi]);
        check("s_operation", s_operation, m_operation[gi]);
        check("s_wdata", s_wdata, m_wdata[gi]);
        check("m_valid_issue", m_valid, 0);
        if (viol) m_request[gi] = 1'b0;
        for (int w = 0; w < waits; w++) begin
            tick;
            check("s_request_hold", s_request, 1);
            check("grant_hold", grant_id, gi);
        end
        if (!to) begin
            s_valid = 1'b1;
            s_rdata = rd;
            s_evict = ev;
        end
        tick;
        check("m_valid_rise", m_valid, 4'b1 << g);
        check("s_request_fall", s_request, 0);
        check("m_rdata", m_rdata, to ? 8'h00 : rd);
        check("m_evict", m_evict, to ? 1'b0 : ev);
`ifdef CACHE_ARB_TIMEOUT_EN
        check("m_error", m_error, to);
`endif
        if (mode == 2 || !s_valid || !m_request[gi]) begin
            m_request[gi] = 1'b0;
            s_valid = 1'b0;
        end else begin
            if (mode == 0) m_request[gi] = 1'b0;
            else s_valid = 1'b0;
            tick;
            check("m_valid_wait", m_valid, 4'b1 << g);
            m_request[gi] = 1'b0;
            s_valid = 1'b0;
        end
        tick;
        check("m_valid_fall", m_valid, 0);
        check("grant_idle", grant_id, 0);
        rr = (g + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done;
        tick;
        tick;
        check("rst_s_request", s_request, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_grant", grant_id, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_m_rdata", m_rdata, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) do_round(4'hF, $urandom_range(0, 3), -1, -1, $urandom_range(0, 2), 1'b0);
        m_request = '0;
        tick;
        m_operation[1] = INST_READ;
        m_addr[1] = 32'h0000_1000;
        m_wdata[1] = 8'h00;
        m_request[1] = 1'b1;
        do_round(4'h0, 3, 8'hA5, 0, 0, 1'b0);
        do_round(4'b0001, 1, -1, 1, 1, 1'b0);
        m_request = 4'b1011;
        tick;
        check("rst_pre_request", s_request, 1);
        tick;
        #1 reset = 1'b1;
        #1;
        check("async_s_request", s_request, 0);
        check("async_m_valid", m_valid, 0);
        check("async_grant", grant_id, 0);
        check("async_s_addr", s_addr, 0);
        check("async_s_operation", s_operation, 0);
        check("async_s_wdata", s_wdata, 0);
        check("async_m_rdata", m_rdata, 0);
        check("async_m_evict", m_evict, 0);
        m_request = 4'b0100;
        m_addr[2] = 32'hC0DE_0002;
        m_operation[2] = INST_WRITE;
        m_wdata[2] = 8'h3C;
        tick;
        reset = 1'b0;
        rr = 0;
        do_round(4'h0, 2, -1, -1, 2, 1'b0);
`ifdef CACHE_ARB_TIMEOUT_EN
        do_round(4'b1000, -1, -1, -1, 0, 1'b0);
        do_round(4'b0010, 2, 8'h5A, 0, 2, 1'b0);
        do_round(4'b0100, TO - 1, -1, -1, 1, 1'b0);
`endif
        for (int i = 0; i < 60; i++)
            do_round(4'($urandom_range(1, 15)), $urandom_range(0, 4), -1, -1, $urandom_range(0, 2), $urandom_range(0, 7) == 0);
        m_request = '0;
        done = 0;
        m_request1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            check("n1_overlap", s_request1 & m_valid1, 0);
            check("n1_grant", grant_id1, 0);
            if (m_valid1) done++;
            m_request1 = !m_valid1;
            s_valid1 = s_request1;
            s_rdata1 = 8'(i);
        end
        check("n1_throughput", done > 0 && done <= 14, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
